// File: rtl/ttr_pkg.sv
// Shared types and constants for the triple-time-redundant scheduler.
package ttr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN0 = 3'd1,
    RUN1 = 3'd2,
    RUN2 = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [1:0] PHASE_IDLE = 2'd3;
  localparam int ERRCNT_W = 8;

endpackage

// File: rtl/ttr_vote.sv
// Bitwise 2-of-3 majority voter with disagreement flags.
module ttr_vote #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] maj,
  output logic         err,
  output logic         fatal
);

  logic ab_diff, bc_diff, ac_diff;

  assign ab_diff = (a != b);
  assign bc_diff = (b != c);
  assign ac_diff = (a != c);

  assign maj   = (a & b) | (b & c) | (a & c);
  assign err   = ab_diff | bc_diff | ac_diff;
  assign fatal = ab_diff & bc_diff & ac_diff;

endmodule

// File: rtl/ttr_sched.sv
// Runs each operand three times through a shared datapath and votes the results.
// Optional saturating error counter port err_cnt is enabled by TTR_ERRCNT_EN.
module ttr_sched
  import ttr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] dp_op,
  output logic [1:0]   dp_phase,
  input  logic [W-1:0] dp_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic         out_fatal
`ifdef TTR_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  state_t       st0_reg, st1_reg, st2_reg;
  state_t       state_v, state_next;
  logic [2:0]   state_maj;
  logic         state_err_unused, state_fatal_unused;
  logic [W-1:0] op_reg;
  logic [W-1:0] r_reg [3];
  logic         vote_err, vote_fatal;
  logic         accept;

  // The state copies are voted every cycle, so one upset copy is outvoted and rewritten.
  ttr_vote #(.N(3)) u_state_vote (
    .a     (st0_reg),
    .b     (st1_reg),
    .c     (st2_reg),
    .maj   (state_maj),
    .err   (state_err_unused),
    .fatal (state_fatal_unused)
  );

  assign state_v = state_t'(state_maj);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st0_reg <= IDLE;
      st1_reg <= IDLE;
      st2_reg <= IDLE;
    end else begin
      st0_reg <= state_next;
      st1_reg <= state_next;
      st2_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state_v)
      IDLE:    state_next = in_valid ? RUN0 : IDLE;
      RUN0:    state_next = RUN1;
      RUN1:    state_next = RUN2;
      RUN2:    state_next = HOLD;
      HOLD: begin
        if (out_ready) state_next = in_valid ? RUN0 : IDLE;
        else           state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    dp_op     = '0;
    dp_phase  = PHASE_IDLE;
    out_valid = 1'b0;
    case (state_v)
      IDLE: in_ready = 1'b1;
      RUN0: begin
        dp_op    = op_reg;
        dp_phase = 2'd0;
      end
      RUN1: begin
        dp_op    = op_reg;
        dp_phase = 2'd1;
      end
      RUN2: begin
        dp_op    = op_reg;
        dp_phase = 2'd2;
      end
      HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready;

  // dp_phase is only 0..2 during a RUN state, so it selects the capture slot directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg <= '0;
      for (int k = 0; k < 3; k++) r_reg[k] <= '0;
    end else begin
      if (accept) op_reg <= in_data;
      for (int k = 0; k < 3; k++) begin
        if (dp_phase == 2'(k)) r_reg[k] <= dp_res;
      end
    end
  end

  ttr_vote #(.N(W)) u_res_vote (
    .a     (r_reg[0]),
    .b     (r_reg[1]),
    .c     (r_reg[2]),
    .maj   (out_data),
    .err   (vote_err),
    .fatal (vote_fatal)
  );

  assign out_err   = out_valid & vote_err;
  assign out_fatal = out_valid & vote_fatal;

`ifdef TTR_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_reg <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt_reg != {ERRCNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_ttr_sched.sv
// Directed bench for ttr_sched: clean, single-fault, triple-fault, backpressure, reset abort, state upset.
module tb_ttr_sched;
  import ttr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] dp_op;
  logic [1:0] dp_phase;
  logic [7:0] dp_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_fatal;
`ifdef TTR_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int mode = 0;

  always #5 clk = ~clk;

  ttr_sched #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dp_op     (dp_op),
    .dp_phase  (dp_phase),
    .dp_res    (dp_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_fatal (out_fatal)
`ifdef TTR_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // Datapath model: 0 ideal (+1), 1 fault in phase 1, 2 all three differ.
  always_comb begin
    dp_res = dp_op + 8'd1;
    if (mode == 1) dp_res = (dp_phase == 2'd1) ? 8'h55 : 8'h11;
    else if (mode == 2) begin
      case (dp_phase)
        2'd0:    dp_res = 8'h01;
        2'd1:    dp_res = 8'h02;
        default: dp_res = 8'h04;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
`ifdef TTR_ERRCNT_EN
    check(tag, err_cnt, exp_cnt);
`endif
  endtask

  // Presents one request with out_ready=1 and walks it through RUN0..HOLD.
  task automatic run_op(input string tag, input logic [7:0] d, input logic [7:0] exp_d,
                        input logic exp_e, input logic exp_f);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check({tag, ".in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.phase%0d", tag, k), dp_phase, k);
      check($sformatf("%s.op%0d", tag, k), dp_op, d);
      if (k < 2) tick();
    end
    tick();
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".out_data"}, out_data, exp_d);
    check({tag, ".out_err"}, out_err, exp_e);
    check({tag, ".out_fatal"}, out_fatal, exp_f);
    check({tag, ".hold_phase"}, dp_phase, 3);
    tick();
    if (exp_e && exp_cnt < 255) exp_cnt++;
    check({tag, ".idle_valid"}, out_valid, 0);
    check({tag, ".idle_phase"}, dp_phase, 3);
    check_cnt({tag, ".err_cnt"});
    $display("op %s: in=%0h out=%0h err=%0b fatal=%0b", tag, d, out_data, exp_e, exp_f);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_err", out_err, 0);
    check("rst.out_fatal", out_fatal, 0);
    check("rst.dp_op", dp_op, 0);
    check("rst.dp_phase", dp_phase, 3);
    check("rst.out_data", out_data, 0);
    check_cnt("rst.err_cnt");
    reset = 1'b0;
    tick();

    mode = 0;
    run_op("ideal", 8'h10, 8'h11, 1'b0, 1'b0);
    mode = 1;
    run_op("single", 8'h10, 8'h11, 1'b1, 1'b0);
    mode = 2;
    run_op("triple", 8'h10, 8'h00, 1'b1, 1'b1);

    // Backpressure on HOLD, then output and input handshakes in the same cycle.
    mode      = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h20;
    tick();
    in_data = 8'h30;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp.run_ready%0d", k), in_ready, 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.valid%0d", i), out_valid, 1);
      check($sformatf("bp.data%0d", i), out_data, 8'h21);
      check($sformatf("bp.err%0d", i), out_err, 0);
      check($sformatf("bp.ready%0d", i), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", in_ready, 1);
    check("bp.release_valid", out_valid, 1);
    check("bp.release_data", out_data, 8'h21);
    $display("op backpressure: out=%0h handed off with next request 30", out_data);
    tick();
    in_valid = 1'b0;
    check("b2b.phase0", dp_phase, 0);
    check("b2b.op", dp_op, 8'h30);
    tick();
    tick();
    tick();
    check("b2b.valid", out_valid, 1);
    check("b2b.data", out_data, 8'h31);
    $display("op back2back: in=30 out=%0h", out_data);
    tick();
    check("b2b.idle", out_valid, 0);
    check_cnt("b2b.err_cnt");

    // Reset while in RUN1 aborts the operation immediately.
    in_valid = 1'b1;
    in_data  = 8'h40;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort.phase1", dp_phase, 1);
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    check("abort.phase", dp_phase, 3);
    check("abort.valid", out_valid, 0);
    check("abort.ready", in_ready, 1);
    check("abort.op", dp_op, 0);
    check_cnt("abort.err_cnt");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("abort.no_out%0d", i), out_valid, 0);
      tick();
    end
    $display("op abort: operand 40 discarded by reset in RUN1");

    // Upset one state copy during RUN0; the vote must mask it.
    in_valid = 1'b1;
    in_data  = 8'h50;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    force dut.st1_reg = RUN2;
    #1;
    check("seu.phase0", dp_phase, 0);
    #1;
    release dut.st1_reg;
    tick();
    check("seu.phase1", dp_phase, 1);
    check("seu.copy0", dut.st0_reg, RUN1);
    check("seu.copy1", dut.st1_reg, RUN1);
    check("seu.copy2", dut.st2_reg, RUN1);
    tick();
    check("seu.phase2", dp_phase, 2);
    tick();
    check("seu.valid", out_valid, 1);
    check("seu.data", out_data, 8'h51);
    check("seu.err", out_err, 0);
    $display("op seu: in=50 out=%0h", out_data);
    tick();
    check("seu.idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
